// File: rtl/cache_pkg.sv
// Shared types and constants for the cache access arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cache_pkg;

    // Arbiter sequencing states; encoding is fixed so waveforms decode predictably.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

    localparam int DEFAULT_ADDR_W = 32;
    localparam int STAT_W         = 12;

    // Saturating increment for the statistics counters: sticks at all-ones.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/cache_access_arbiter_rr_pick.sv
// Round-robin picker: first set request bit strictly after last_i, wrapping.
// Latency: purely combinational.
// Backpressure: none; vld_o is low when no request is pending.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [N-1:0]     gnt_o,
    output logic             vld_o
);

    // Scan N positions starting one past the previous winner; first hit wins.
    always_comb begin
        logic found;
        found = 1'b0;
        gnt_o = '0;
        for (int i = 1; i <= N; i++) begin
            if (!found && req_i[(int'(last_i) + i) % N]) begin
                gnt_o[(int'(last_i) + i) % N] = 1'b1;
                found = 1'b1;
            end
        end
        vld_o = found;
    end

endmodule

// File: rtl/cache_access_arbiter.sv
// Round-robin arbiter sharing one cache lookup engine; optional CACHE_ARB_STATS_EN adds read/write/miss counters.
// Latency: request seen in IDLE at T -> cache strobe at T+1 -> done_o at T+3 earliest; 4-cycle minimum period.
// Backpressure: requesters hold req_i until done_o; a WAIT timeout of TIMEOUT cycles completes with err_o.
module cache_access_arbiter
    import cache_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ-1:0]        req_we_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [NUM_REQ-1:0]        done_o,
    output logic                      hit_o,
    output logic                      err_o,
    output logic                      cache_req_o,
    output logic [ADDR_W-1:0]         cache_addr_o,
    output logic                      cache_we_o,
    input  logic                      cache_ack_i,
    input  logic                      cache_hit_i
`ifdef CACHE_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0]         num_reads,
    output logic [STAT_W-1:0]         num_writes,
    output logic [STAT_W-1:0]         num_misses
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    arb_state_e          state_q, state_d;
    logic [NUM_REQ-1:0]  winner_q, winner_d;
    logic [IDX_W-1:0]    widx_q, widx_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic                hit_q, hit_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [NUM_REQ-1:0]  pick_oh;
    logic                pick_vld;
    logic [IDX_W-1:0]    pick_idx;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i  (req_i),
        .last_i (last_q),
        .gnt_o  (pick_oh),
        .vld_o  (pick_vld)
    );

    // One-hot winner to binary index, used for the address/we mux and last_grant.
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_oh[i]) begin
                pick_idx = IDX_W'(i);
            end
        end
    end

    // State and transaction registers; reset aborts any in-flight transaction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            winner_q <= '0;
            widx_q   <= '0;
            last_q   <= IDX_W'(NUM_REQ - 1);
            addr_q   <= '0;
            we_q     <= 1'b0;
            hit_q    <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            widx_q   <= widx_d;
            last_q   <= last_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            hit_q    <= hit_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state: pick and latch in IDLE, strobe in ISSUE, ack/timeout in WAIT, retire in DONE.
    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        widx_d   = widx_q;
        last_d   = last_q;
        addr_d   = addr_q;
        we_d     = we_q;
        hit_d    = hit_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    winner_d = pick_oh;
                    widx_d   = pick_idx;
                    addr_d   = req_addr_i[int'(pick_idx)*ADDR_W +: ADDR_W];
                    we_d     = req_we_i[pick_idx];
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Ack takes priority over the final timeout count.
                if (cache_ack_i) begin
                    hit_d   = cache_hit_i;
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    hit_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                last_d  = widx_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from state so reset clears them immediately.
    always_comb begin
        gnt_o        = (state_q != ST_IDLE) ? winner_q : '0;
        done_o       = (state_q == ST_DONE) ? winner_q : '0;
        hit_o        = (state_q == ST_DONE) && hit_q;
        err_o        = (state_q == ST_DONE) && err_q;
        cache_req_o  = (state_q == ST_ISSUE);
        cache_addr_o = addr_q;
        cache_we_o   = we_q;
    end

`ifdef CACHE_ARB_STATS_EN
    logic [STAT_W-1:0] reads_q, writes_q, misses_q;

    // Saturating per-transaction statistics, updated in the DONE cycle; timeouts are not misses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reads_q  <= '0;
            writes_q <= '0;
            misses_q <= '0;
        end else if (state_q == ST_DONE) begin
            if (we_q) begin
                writes_q <= sat_inc(writes_q);
            end else begin
                reads_q <= sat_inc(reads_q);
            end
            if (!hit_q && !err_q) begin
                misses_q <= sat_inc(misses_q);
            end
        end
    end

    assign num_reads  = reads_q;
    assign num_writes = writes_q;
    assign num_misses = misses_q;
`endif

endmodule
